simple_widthadapt_1_to_x: RTL and testbench
===========================================

# simple_widthadapt_1_to_x

Narrow-to-wide stream packer: gathers `p_x` consecutive `p_iwidth`-bit beats into one `p_iwidth*p_x`-bit word behind a valid/ready handshake. It is the companion of the wide-to-narrow unpacker. It sits on the ingest side of the sensor/frame-buffer datapath, where byte or nibble streams must be widened to memory or pixel words. Slice ordering mirrors the unpacker, so unpack→pack is the identity.

## Interface
Parameters:
- `p_iwidth`, 8, width of one input beat.
- `p_x`, 2, beats per output word; power of two, ≥2.
- `p_owidth` (localparam), `p_iwidth*p_x`, output word width.
- `p_xw` (localparam), `$clog2(p_x)`, beat counter width.

Ports:
- `i_clk` in 1: single clock, all logic on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: input beat valid.
- `i_data` in `p_iwidth`: input beat.
- `o_ready` out 1: block accepts a beat this cycle.
- `o_valid` out 1: assembled word available.
- `o_data` out `p_owidth`: assembled word.
- `i_ready` in 1: downstream accepts the word this cycle.

## Operation
- Beat accepted when `i_valid & o_ready`; word consumed when `o_valid & i_ready`.
- State:
  - Beat counter `s_count` (`p_xw` bits, 0..p_x-1).
  - Accumulator `s_acc` (`p_owidth`).
  - Output register `o_data`/`o_valid`.
- Packing order: the first accepted beat of a word lands in `o_data[p_owidth-1 -: p_iwidth]` (MSB slice). Beat k lands in slice `p_x-1-k`.
- Non-final beat (`s_count != p_x-1`): write its slice of `s_acc`, then `s_count+1`. This proceeds regardless of output register occupancy.
- Final beat (`s_count == p_x-1`):
  - Transfer the full word (`s_acc` plus this beat in slice 0) directly into `o_data`.
  - Set `o_valid=1` and `s_count=0`.
- `o_ready = (s_count != p_x-1) | ~o_valid | i_ready`. Stall only when the final beat would overwrite an unconsumed word. The combinational path `i_ready`→`o_ready` is allowed.
- Output register clears when consumed with no new word loading: `o_valid=0`.
- Simultaneous consume and final-beat load: the new word replaces the old one, `o_valid` stays 1, and there is no bubble.
- `i_valid` low mid-word: the partial word holds indefinitely and is not emitted.
- Counter wrap: `p_x-1`→0 only on final-beat accept.
- Reset, including mid-word: `s_count=0`, `s_acc=0`, `o_valid=0`, `o_data=0`, so `o_ready=1`. Partial and pending words are discarded.

## Timing
- Latency: final beat accepted at edge N → `o_valid=1` with the word after edge N (visible cycle N+1).
- Throughput: one beat per cycle sustained when `i_ready` is held high; one word every `p_x` cycles.
- `o_data` is stable while `o_valid & ~i_ready`.
- Reset values: `o_valid=0`, `o_data=0`, `o_ready=1`.

## Configuration
- `WIDTHADAPT_FLUSH_EN` defined:
  - Adds `i_last` (in, 1) and `o_last` (out, 1).
  - An accepted beat with `i_last=1` is treated as final regardless of `s_count`. Slices not yet written are zero-filled, and `o_last=1` accompanies that word.
  - The `o_ready` stall term then uses `((s_count==p_x-1) | i_last)`.
  - `o_last` resets to 0 and has the same stability rules as `o_data`.
- Not defined: the ports are absent, and words are emitted only after exactly `p_x` beats.

## Structure
- Shared package `widthadapt_pkg`:
  - Function `f_slice_lsb(idx, width, x)` returning the slice base bit, used by both packer and unpacker to guarantee matching order.
  - Parameter-legality check (power-of-two `p_x`) as an elaboration-time function.
- Single module, no sub-modules. The accumulator/counter and the output register live in two `always_ff` processes.

## Test plan
(`p_iwidth=4`, `p_x=4`, `p_owidth=16` unless noted)
- Continuous beats 0xA,0xB,0xC,0xD with `i_ready=1` → `o_data=16'hABCD`, `o_valid` for one cycle, one cycle after the 4th beat; `o_ready` constantly 1.
- Two words back-to-back (0x1..0x4, 0x5..0x8), `i_ready=0` until after the 8th beat is offered:
  - `o_data=16'h1234` held.
  - `o_ready=0` while the 8th beat is pending.
  - On `i_ready=1`, 0x1234 is consumed and 0x5678 loads in the same edge with `o_valid` continuous.
- Gapped input (`i_valid` toggling) → same words, no lost or duplicated beats; the partial word is never emitted.
- Reset asserted after 2 beats, then beats 0x9,0xA,0xB,0xC → `o_data=16'h9ABC`; no residue of the earlier beats.
- Round-trip: unpacker(`p_iwidth=16`, `p_x=4`) → this block, random words with random `i_ready` → output sequence equals input sequence.
- `WIDTHADAPT_FLUSH_EN`: beats 0xE,0xF with `i_last` on 0xF → `o_data=16'hEF00`, `o_last=1`; the next word starts at the MSB slice.

Source files
------------

// File: rtl/widthadapt_pkg.sv
// widthadapt_pkg: slice ordering and parameter checks shared by the width packer and unpacker
package widthadapt_pkg;
  function automatic int f_slice_lsb(input int idx, input int width, input int x);
    return (x - 1 - idx) * width;
  endfunction
  function automatic bit f_is_pow2(input int x);
    return (x >= 2) && ((x & (x - 1)) == 0);
  endfunction
endpackage

// File: rtl/simple_widthadapt_1_to_x.sv
// simple_widthadapt_1_to_x: packs p_x narrow beats (first beat in the MSB slice) into one wide word
// Optional WIDTHADAPT_FLUSH_EN adds i_last/o_last for early, zero-filled word termination.
module simple_widthadapt_1_to_x
  import widthadapt_pkg::*;
#(
  parameter int p_iwidth = 8,
  parameter int p_x = 2,
  localparam int p_owidth = p_iwidth * p_x,
  localparam int p_xw = $clog2(p_x)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [p_iwidth-1:0] i_data,
`ifdef WIDTHADAPT_FLUSH_EN
  input  logic                i_last,
  output logic                o_last,
`endif
  output logic                o_ready,
  output logic                o_valid,
  output logic [p_owidth-1:0] o_data,
  input  logic                i_ready
);
  if (!f_is_pow2(p_x)) begin : g_bad_x
    $error("p_x must be a power of two >= 2");
  end
  logic [p_xw-1:0] s_count;
  logic [p_owidth-1:0] s_acc, merged, mask, shifted;
  logic last_beat, take;
`ifdef WIDTHADAPT_FLUSH_EN
  assign last_beat = (s_count == p_xw'(p_x - 1)) | i_last;
`else
  assign last_beat = (s_count == p_xw'(p_x - 1));
`endif
  assign o_ready = ~last_beat | ~o_valid | i_ready;
  assign take = i_valid & o_ready;
  always_comb begin
    mask = {p_owidth{1'b0}};
    mask[p_iwidth-1:0] = {p_iwidth{1'b1}};
    mask = mask << f_slice_lsb(int'(s_count), p_iwidth, p_x);
    shifted = p_owidth'(i_data) << f_slice_lsb(int'(s_count), p_iwidth, p_x);
    merged = (s_acc & ~mask) | shifted;
  end
  // accumulator is cleared on every final beat so flushed words are zero-filled below the last slice
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_count <= '0;
      s_acc <= '0;
    end else if (take) begin
      s_count <= last_beat ? '0 : s_count + 1'b1;
      s_acc <= last_beat ? '0 : merged;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
`ifdef WIDTHADAPT_FLUSH_EN
      o_last <= 1'b0;
`endif
    end else if (take & last_beat) begin
      o_valid <= 1'b1;
      o_data <= merged;
`ifdef WIDTHADAPT_FLUSH_EN
      o_last <= i_last;
`endif
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_simple_widthadapt_1_to_x.sv
// tb_simple_widthadapt_1_to_x: table-driven check of the 4x4-bit packer plus reset and flush sequences
module tb_simple_widthadapt_1_to_x;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_ready = 0;
  logic [3:0] i_data = '0;
  logic o_ready, o_valid;
  logic [15:0] o_data;
`ifdef WIDTHADAPT_FLUSH_EN
  logic i_last = 0, o_last;
`endif
  int n_vec = 0, n_err = 0;
  always #5 i_clk = ~i_clk;
  simple_widthadapt_1_to_x #(.p_iwidth(4), .p_x(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
`ifdef WIDTHADAPT_FLUSH_EN
    .i_last(i_last), .o_last(o_last),
`endif
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready)
  );
  typedef struct {
    logic v;
    logic [3:0] d;
    logic r;
    logic er;
    logic ev;
    logic [15:0] ed;
  } vec_t;
  vec_t vt[$];
  task automatic add(input logic v, input logic [3:0] d, input logic r, input logic er, input logic ev, input logic [15:0] ed);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.er = er; x.ev = ev; x.ed = ed;
    vt.push_back(x);
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic beat(input logic [3:0] d, input logic r);
    @(negedge i_clk);
    i_valid = 1; i_data = d; i_ready = r;
  endtask
  initial begin
    add(1, 4'hA, 1, 1, 0, 0); add(1, 4'hB, 1, 1, 0, 0);
    add(1, 4'hC, 1, 1, 0, 0); add(1, 4'hD, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 16'hABCD); add(0, 4'h0, 1, 1, 0, 0);
    add(1, 4'h1, 0, 1, 0, 0); add(1, 4'h2, 0, 1, 0, 0);
    add(1, 4'h3, 0, 1, 0, 0); add(1, 4'h4, 0, 1, 0, 0);
    add(1, 4'h5, 0, 1, 1, 16'h1234); add(1, 4'h6, 0, 1, 1, 16'h1234);
    add(1, 4'h7, 0, 1, 1, 16'h1234); add(1, 4'h8, 0, 0, 1, 16'h1234);
    add(1, 4'h8, 0, 0, 1, 16'h1234); add(1, 4'h8, 1, 1, 1, 16'h1234);
    add(0, 4'h0, 0, 1, 1, 16'h5678); add(0, 4'h0, 1, 1, 1, 16'h5678);
    add(0, 4'h0, 1, 1, 0, 0);
    add(1, 4'h3, 1, 1, 0, 0); add(0, 4'h7, 1, 1, 0, 0);
    add(1, 4'h0, 1, 1, 0, 0); add(0, 4'h9, 1, 1, 0, 0);
    add(0, 4'h9, 1, 1, 0, 0); add(1, 4'hF, 1, 1, 0, 0);
    add(0, 4'h5, 1, 1, 0, 0); add(1, 4'h2, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 16'h30F2); add(0, 4'h0, 1, 1, 0, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    #1;
    chk("reset o_valid", 16'(o_valid), 16'h0);
    chk("reset o_data", o_data, 16'h0);
    chk("reset o_ready", 16'(o_ready), 16'h1);
    foreach (vt[i]) begin
      @(negedge i_clk);
      i_valid = vt[i].v; i_data = vt[i].d; i_ready = vt[i].r;
      #1;
      chk($sformatf("vec%0d o_ready", i), 16'(o_ready), 16'(vt[i].er));
      chk($sformatf("vec%0d o_valid", i), 16'(o_valid), 16'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d o_data", i), o_data, vt[i].ed);
    end
    for (int k = 1; k <= 6; k++) beat(4'(k), 0);
    @(negedge i_clk);
    i_valid = 0; i_rst = 1;
    @(negedge i_clk);
    i_rst = 0;
    #1;
    chk("midword reset o_valid", 16'(o_valid), 16'h0);
    chk("midword reset o_data", o_data, 16'h0);
    chk("midword reset o_ready", 16'(o_ready), 16'h1);
    beat(4'h9, 0); beat(4'hA, 0); beat(4'hB, 0); beat(4'hC, 0);
    @(negedge i_clk);
    i_valid = 0;
    #1;
    chk("post reset o_valid", 16'(o_valid), 16'h1);
    chk("post reset o_data", o_data, 16'h9ABC);
    @(negedge i_clk);
    #1;
    chk("stall hold o_data", o_data, 16'h9ABC);
    i_ready = 1;
    @(negedge i_clk);
    #1;
    chk("consumed o_valid", 16'(o_valid), 16'h0);
`ifdef WIDTHADAPT_FLUSH_EN
    beat(4'hE, 1);
    @(negedge i_clk);
    i_valid = 1; i_data = 4'hF; i_last = 1;
    @(negedge i_clk);
    i_valid = 0; i_last = 0;
    #1;
    chk("flush o_valid", 16'(o_valid), 16'h1);
    chk("flush o_data", o_data, 16'hEF00);
    chk("flush o_last", 16'(o_last), 16'h1);
    beat(4'h1, 1); beat(4'h2, 1); beat(4'h3, 1); beat(4'h4, 1);
    @(negedge i_clk);
    i_valid = 0;
    #1;
    chk("after flush o_data", o_data, 16'h1234);
    chk("after flush o_last", 16'(o_last), 16'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
